systolic_wavefront_seq: RTL
===========================

SYSTOLIC_WAVEFRONT_SEQ -- requirements
Module: systolic_wavefront_seq

Interface
REQ-001 Parameter ROWS, default 8, number of array rows (≥2).
REQ-002 Parameter COLS, default 8, number of array columns (≥2).
REQ-003 Parameter KW, default 16, width of the reduction-length input.
REQ-004 clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request a job; accepted only in IDLE.
REQ-006 mode  in  2  dataflow: 00 input-stationary, 01 weight-stationary, 10 output-stationary, 11 illegal.
REQ-007 k_len  in  KW  reduction length; 0 is illegal.
REQ-008 abort  in  1  cancel the current job.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  one-cycle pulse when start is rejected.
REQ-012 load_en  out  1  stationary-operand load strobe; load_row  out  clog2(ROWS)  row being loaded.
REQ-013 row_feed_en  out  ROWS  per-row skewed streaming enable; col_feed_en  out  COLS  per-column skewed streaming enable.
REQ-014 mac_en  out  1  MAC enable; accum_clear  out  1  accumulator clear.
REQ-015 drain_en  out  1  result drain strobe; drain_row  out  clog2(ROWS)  row being drained.

Function
REQ-016 States: IDLE, LOAD, COMPUTE, DRAIN, DONE; all outputs are registered.
REQ-017 IDLE + start + legal mode + k_len≠0: latch mode and k_len; go to LOAD (mode 00/01) or COMPUTE (mode 10).
REQ-018 IDLE + start + (mode==11 or k_len==0): stay in IDLE; pulse err for 1 cycle; nothing is latched.
REQ-019 start outside IDLE is ignored.
REQ-020 LOAD: lasts exactly ROWS cycles; load_en=1; load_row counts 0..ROWS-1; mac_en=0; accum_clear=1; then go to COMPUTE.
REQ-021 COMPUTE: lasts exactly T = k_len+ROWS+COLS-2 cycles, with local counter t = 0..T-1.
REQ-022 In COMPUTE, mac_en=1 for every cycle.
REQ-023 In COMPUTE, row_feed_en[r]=1 iff r ≤ t < r+k_len.
REQ-024 In COMPUTE, col_feed_en[c]=1 iff c ≤ t < c+k_len.
REQ-025 In mode 10, accum_clear=1 only when t==0 of COMPUTE.
REQ-026 COMPUTE exit: go to DRAIN in mode 10; go to DONE in modes 00/01.
REQ-027 DRAIN: lasts ROWS cycles; drain_en=1; drain_row counts 0..ROWS-1; mac_en=0; then go to DONE.
REQ-028 DONE: done=1 for one cycle; then go to IDLE; a start in this cycle is ignored.
REQ-029 abort in any non-IDLE state: go to IDLE next cycle; no done; all strobes are 0 from that cycle.
REQ-030 abort and start together in IDLE: abort wins; start is ignored.
REQ-031 Counter width is KW+clog2(ROWS+COLS)+1; T is computed without overflow for k_len = 2^KW-1.

Reset
REQ-032 On reset, state=IDLE and all outputs/counters are 0, including done, err, busy, and all enables and indices.
REQ-033 Reset mid-job: the job is discarded with no done or err pulse; start is accepted on the first clock after reset deasserts.

Structure
REQ-034 Package systolic_pkg holds the state enum, the mode constants (MODE_IS, MODE_WS, MODE_OS, MODE_ILLEGAL), and the helper for computing T.
REQ-035 Sub-module systolic_skew_gen (combinational, parameterized by lane count) produces the feed-enable vector from t and k_len; it is instantiated once for rows and once for columns.

Verification (ROWS=COLS=4; start accepted at edge 0)
REQ-036 mode=01, k_len=3 -> load_en in cycles 1-4 with load_row 0,1,2,3; COMPUTE in cycles 5-13 (T=9); row_feed_en[3] high in cycles 8-10; done in cycle 14.
REQ-037 mode=10, k_len=2 -> no load_en; COMPUTE in cycles 1-8 with accum_clear only in cycle 1; drain_en in cycles 9-12; done in cycle 13.
REQ-038 mode=11 or k_len=0 with start -> err high in cycle 1; busy stays 0; no other strobe fires.
REQ-039 mode=01, k_len=5, abort in cycle 7 -> IDLE in cycle 8; no done; a new start in cycle 8 is accepted.
REQ-040 Async reset asserted mid-COMPUTE -> all outputs 0 immediately; start at k_len=1 after release completes with T=7.
REQ-041 start pulsed in cycles 3 and 14 of the REQ-036 job -> both ignored; exactly one done pulse.

Source files
------------

// File: rtl/systolic_pkg.sv
// +----------------------------------------------------------------------+
// | systolic_pkg -- shared state, dataflow modes and phase-length helper |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] MODE_IS      = 2'b00;
    localparam logic [1:0] MODE_WS      = 2'b01;
    localparam logic [1:0] MODE_OS      = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    // Length of the skewed wavefront: the last lane starts rows+cols-2 cycles late.
    function automatic logic [63:0] calc_compute_len(input logic [63:0] k_len,
                                                     input int rows,
                                                     input int cols);
        return k_len + 64'(rows) + 64'(cols) - 64'd2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_skew_gen.sv
// +----------------------------------------------------------------------+
// | systolic_skew_gen -- lane l is fed while l <= t < l + k_len          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module systolic_skew_gen #(
    parameter int LANES = 8,
    parameter int KW    = 16,
    parameter int CW    = 21
) (
    input  logic             en_i,
    input  logic [CW-1:0]    t_i,
    input  logic [KW-1:0]    k_len_i,
    output logic [LANES-1:0] feed_o
);

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [CW-1:0] w_lo;
            logic [CW-1:0] w_hi;
            assign w_lo      = CW'(l);
            assign w_hi      = CW'(l) + CW'(k_len_i);
            assign feed_o[l] = en_i && (t_i >= w_lo) && (t_i < w_hi);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_wavefront_seq.sv
// +----------------------------------------------------------------------+
// | systolic_wavefront_seq -- load/compute/drain sequencer for an array  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module systolic_wavefront_seq
    import systolic_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int KW   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [1:0]              mode_i,
    input  logic [KW-1:0]           k_len_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    load_en_o,
    output logic [$clog2(ROWS)-1:0] load_row_o,
    output logic [ROWS-1:0]         row_feed_en_o,
    output logic [COLS-1:0]         col_feed_en_o,
    output logic                    mac_en_o,
    output logic                    accum_clear_o,
    output logic                    drain_en_o,
    output logic [$clog2(ROWS)-1:0] drain_row_o
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = KW + $clog2(ROWS + COLS) + 1;
    localparam logic [CW-1:0] ROW_LAST = CW'(ROWS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic [CW-1:0] t_last;

    logic          busy_d, done_d, err_d, load_en_d, mac_en_d, accum_clear_d, drain_en_d;
    logic [RW-1:0] load_row_d, drain_row_d;
    logic          feed_active;
    logic [ROWS-1:0] row_feed_d;
    logic [COLS-1:0] col_feed_d;

    assign t_last = CW'(calc_compute_len(64'(k_len_q), ROWS, COLS) - 64'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            k_len_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            k_len_q <= k_len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        k_len_d = k_len_q;
        err_d   = 1'b0;

        if (state_q != ST_IDLE && abort_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        if (mode_i == MODE_ILLEGAL || k_len_i == '0) begin
                            err_d = 1'b1;
                        end else begin
                            mode_d  = mode_i;
                            k_len_d = k_len_i;
                            cnt_d   = '0;
                            state_d = (mode_i == MODE_OS) ? ST_COMPUTE : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == ROW_LAST) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (cnt_q == t_last) begin
                        state_d = (mode_q == MODE_OS) ? ST_DRAIN : ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == ROW_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so the output flops line up with it.
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        load_en_d     = (state_d == ST_LOAD);
        load_row_d    = load_en_d ? cnt_d[RW-1:0] : '0;
        mac_en_d      = (state_d == ST_COMPUTE);
        drain_en_d    = (state_d == ST_DRAIN);
        drain_row_d   = drain_en_d ? cnt_d[RW-1:0] : '0;
        accum_clear_d = load_en_d ||
                        (mac_en_d && mode_d == MODE_OS && cnt_d == '0);
        feed_active   = mac_en_d;
    end

    systolic_skew_gen #(.LANES(ROWS), .KW(KW), .CW(CW)) u_row_skew (
        .en_i    (feed_active),
        .t_i     (cnt_d),
        .k_len_i (k_len_d),
        .feed_o  (row_feed_d)
    );

    systolic_skew_gen #(.LANES(COLS), .KW(KW), .CW(CW)) u_col_skew (
        .en_i    (feed_active),
        .t_i     (cnt_d),
        .k_len_i (k_len_d),
        .feed_o  (col_feed_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            load_en_o     <= 1'b0;
            load_row_o    <= '0;
            row_feed_en_o <= '0;
            col_feed_en_o <= '0;
            mac_en_o      <= 1'b0;
            accum_clear_o <= 1'b0;
            drain_en_o    <= 1'b0;
            drain_row_o   <= '0;
        end else begin
            busy_o        <= busy_d;
            done_o        <= done_d;
            err_o         <= err_d;
            load_en_o     <= load_en_d;
            load_row_o    <= load_row_d;
            row_feed_en_o <= row_feed_d;
            col_feed_en_o <= col_feed_d;
            mac_en_o      <= mac_en_d;
            accum_clear_o <= accum_clear_d;
            drain_en_o    <= drain_en_d;
            drain_row_o   <= drain_row_d;
        end
    end

endmodule

`default_nettype wire
